// File: rtl/dma_bus_master.sv
// dma_bus_master: word-copy DMA engine with a control slave port and a DBus master port.
// Define DMA_IRQ_EN to add o_Irq and the CTRL bit2 interrupt enable.
module dma_bus_master #(
  parameter int ADDR_SEL_BITS = 20,
  parameter int LEN_BITS      = 16
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_SlaveSel,
  input  logic [29-ADDR_SEL_BITS:0] i_RegAddr,
  input  logic [3:0]              i_AV_ByteEn,
  input  logic                    i_AV_Read,
  input  logic                    i_AV_Write,
  output logic [31:0]             o_AV_ReadData,
  input  logic [31:0]             i_AV_WriteData,
  output logic                    o_AV_WaitRequest,
  output logic                    o_DBus_Req,
  input  logic                    i_DBus_Gnt,
  output logic [29:0]             o_DBus_Address,
  output logic [3:0]              o_DBus_ByteEn,
  output logic                    o_DBus_Read,
  output logic                    o_DBus_Write,
  input  logic [31:0]             i_DBus_ReadData,
  output logic [31:0]             o_DBus_WriteData,
  input  logic                    i_DBus_WaitRequest
`ifdef DMA_IRQ_EN
  , output logic                  o_Irq
`endif
);
  typedef enum logic [2:0] {IDLE, REQ, RD, WR, GAP, FIN} state_t;
  state_t state_q, state_d;
  logic [29:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [31:0] data_q, data_d, m_src, m_dst, m_len;
  logic done_q, done_d, req_q, req_d, rd_q, rd_d, wr_q, wr_d;
  logic busy, wr_en, ctl_wr, start, clr, irq_en;
  logic [1:0] ra;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? nw[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
  assign ra     = i_RegAddr[1:0];
  assign busy   = state_q inside {REQ, RD, WR, GAP};
  assign wr_en  = i_SlaveSel && i_AV_Write;
  assign ctl_wr = wr_en && ra == 2'd3 && i_AV_ByteEn[0];
  assign start  = ctl_wr && i_AV_WriteData[0];
  assign clr    = ctl_wr && i_AV_WriteData[1];
  assign m_src  = merge({2'b0, src_q}, i_AV_WriteData, i_AV_ByteEn);
  assign m_dst  = merge({2'b0, dst_q}, i_AV_WriteData, i_AV_ByteEn);
  assign m_len  = merge(32'(len_q), i_AV_WriteData, i_AV_ByteEn);
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    done_d  = done_q && !clr;
    if (wr_en && !busy) begin
      src_d = ra == 2'd0 ? m_src[29:0] : src_q;
      dst_d = ra == 2'd1 ? m_dst[29:0] : dst_q;
      len_d = ra == 2'd2 ? m_len[LEN_BITS-1:0] : len_q;
    end
    case (state_q)
      IDLE, FIN: begin
        state_d = start && len_q != '0 ? REQ : IDLE;
        done_d  = done_d || (start && len_q == '0);
      end
      REQ: state_d = i_DBus_Gnt ? RD : REQ;
      RD: if (!i_DBus_WaitRequest) begin
        data_d  = i_DBus_ReadData;
        state_d = WR;
      end
      WR: if (!i_DBus_WaitRequest) begin
        src_d   = src_q + 30'd1;
        dst_d   = dst_q + 30'd1;
        len_d   = len_q - 1'b1;
        state_d = len_q == LEN_BITS'(1) ? FIN : GAP;
        done_d  = done_d || len_q == LEN_BITS'(1);
      end
      GAP: state_d = REQ;
      default: state_d = IDLE;
    endcase
    req_d  = state_d inside {REQ, RD, WR};
    rd_d   = state_d == RD;
    wr_d   = state_d == WR;
    addr_d = rd_d ? src_d : wr_d ? dst_d : '0;
  end
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
      done_q  <= done_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
    end
`ifdef DMA_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;
  assign irq_en_d = ctl_wr ? i_AV_WriteData[2] : irq_en_q;
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= done_d && irq_en_d;
    end
  assign irq_en = irq_en_q;
  assign o_Irq  = irq_q;
`else
  assign irq_en = 1'b0;
`endif
  assign o_AV_ReadData    = !(i_SlaveSel && i_AV_Read) ? '0 :
                            ra == 2'd0 ? {2'b0, src_q} :
                            ra == 2'd1 ? {2'b0, dst_q} :
                            ra == 2'd2 ? 32'(len_q) : {29'd0, irq_en, done_q, busy};
  assign o_AV_WaitRequest = 1'b0;
  assign o_DBus_Req       = req_q;
  assign o_DBus_Read      = rd_q;
  assign o_DBus_Write     = wr_q;
  assign o_DBus_Address   = addr_q;
  assign o_DBus_ByteEn    = {4{rd_q | wr_q}};
  assign o_DBus_WriteData = data_q;
  logic unused_bits;
  assign unused_bits = ^{i_RegAddr[29-ADDR_SEL_BITS:2], m_src[31:30], m_dst[31:30], m_len[31:LEN_BITS]};
endmodule

// File: tb/tb_dma_bus_master.sv
// tb_dma_bus_master: directed checks of dma_bus_master against a pattern-memory slave model.
module tb_dma_bus_master;
  logic clk = 1'b0, rst = 1'b1;
  logic sel = 1'b0, av_rd = 1'b0, av_wr = 1'b0, gnt = 1'b1, wreq = 1'b0;
  logic [9:0] reg_addr = '0;
  logic [3:0] av_be = '0;
  logic [31:0] av_wdata = '0, rdata = '0;
  logic [31:0] av_rdata, wdata_o;
  logic av_wait, req, bus_rd, bus_wr;
  logic [29:0] bus_addr;
  logic [3:0] bus_be;
`ifdef DMA_IRQ_EN
  logic irq;
`endif
  dma_bus_master dut (
    .i_Clk(clk), .i_Rst(rst), .i_SlaveSel(sel), .i_RegAddr(reg_addr), .i_AV_ByteEn(av_be),
    .i_AV_Read(av_rd), .i_AV_Write(av_wr), .o_AV_ReadData(av_rdata), .i_AV_WriteData(av_wdata),
    .o_AV_WaitRequest(av_wait), .o_DBus_Req(req), .i_DBus_Gnt(gnt), .o_DBus_Address(bus_addr),
    .o_DBus_ByteEn(bus_be), .o_DBus_Read(bus_rd), .o_DBus_Write(bus_wr), .i_DBus_ReadData(rdata),
    .o_DBus_WriteData(wdata_o), .i_DBus_WaitRequest(wreq)
`ifdef DMA_IRQ_EN
    , .o_Irq(irq)
`endif
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  int waits = 0, wleft = 0, stall_err = 0, be_err = 0, ungr_err = 0, req_cnt = 0;
  logic pend = 1'b0, p_rd = 1'b0;
  logic [29:0] p_addr = '0;
  logic [31:0] rd_log[$], wr_log[$], wd_log[$];
  // Slave memory content is a fixed pattern of the word address.
  function automatic logic [31:0] pat(input logic [29:0] a);
    return {2'b0, a} ^ 32'hDEAD0000;
  endfunction
  always @(negedge clk) begin
    if (bus_rd || bus_wr) begin
      if (!pend) begin
        pend = 1'b1; wleft = waits; p_addr = bus_addr; p_rd = bus_rd;
      end else if (bus_addr !== p_addr || bus_rd !== p_rd || bus_wr === bus_rd) stall_err++;
      if (!gnt) ungr_err++;
      wreq = wleft != 0;
      if (wleft != 0) wleft--;
      rdata = pat(bus_addr);
      if (!wreq) begin
        pend = 1'b0;
        if (bus_rd) rd_log.push_back({2'b0, bus_addr});
        else begin wr_log.push_back({2'b0, bus_addr}); wd_log.push_back(wdata_o); end
      end
    end else begin
      pend = 1'b0; wreq = 1'b0;
    end
    if (bus_be !== {4{bus_rd | bus_wr}}) be_err++;
    if (req) req_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cw(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    sel = 1'b1; av_wr = 1'b1; reg_addr = {8'hA5, a}; av_wdata = d; av_be = be;
    @(negedge clk);
    sel = 1'b0; av_wr = 1'b0; av_be = '0;
  endtask
  task automatic cr(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; av_rd = 1'b1; reg_addr = {8'h5A, a};
    #1 d = av_rdata;
    sel = 1'b0; av_rd = 1'b0;
  endtask
  task automatic prog(input logic [29:0] s, input logic [29:0] d, input logic [15:0] n);
    rd_log.delete(); wr_log.delete(); wd_log.delete();
    cw(2'd0, {2'b0, s}); cw(2'd1, {2'b0, d}); cw(2'd2, {16'd0, n});
  endtask
  task automatic wait_done(output int cyc);
    logic [31:0] s;
    cyc = 0;
    cr(2'd3, s);
    while (s[1] !== 1'b1 && cyc < 300) begin
      @(negedge clk); cyc++; cr(2'd3, s);
    end
  endtask
  initial begin
    logic [31:0] v;
    int cyc;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cr(2'd3, v); chk("reset_status", v, 32'h0);
    cr(2'd0, v); chk("reset_src", v, 32'h0);
    chk("reset_req", {31'd0, req}, 32'h0);
    chk("wait_zero", {31'd0, av_wait}, 32'h0);
    chk("unselected_rdata", av_rdata, 32'h0);
    // Copy 3 words, zero waits; start and DONE-clear share one write
    prog(30'h100, 30'h200, 16'd3);
    cw(2'd3, 32'h3);
    cr(2'd3, v); chk("t1_busy", v, 32'h1);
    wait_done(cyc);
    chk("t1_cycles", cyc, 11);
    chk("t1_nrd", rd_log.size(), 3);
    chk("t1_rd0", rd_log[0], 32'h100);
    chk("t1_rd2", rd_log[2], 32'h102);
    chk("t1_wr0", wr_log[0], 32'h200);
    chk("t1_wr2", wr_log[2], 32'h202);
    chk("t1_wd0", wd_log[0], 32'hDEAD0100);
    chk("t1_wd1", wd_log[1], 32'hDEAD0101);
    chk("t1_wd2", wd_log[2], 32'hDEAD0102);
    cr(2'd3, v); chk("t1_status", v, 32'h2);
    cr(2'd2, v); chk("t1_len", v, 32'h0);
    cr(2'd0, v); chk("t1_src_live", v, 32'h103);
    cw(2'd1, 32'h12345678, 4'b0100);
    cr(2'd1, v); chk("byteen_dst", v, 32'h00340203);
    // Two wait states per access
    waits = 2;
    prog(30'h500, 30'h600, 16'd2);
    cw(2'd3, 32'h3);
    wait_done(cyc);
    chk("t2_cycles", cyc, 15);
    chk("t2_wd0", wd_log[0], 32'hDEAD0500);
    chk("t2_wd1", wd_log[1], 32'hDEAD0501);
    chk("t2_wr1", wr_log[1], 32'h601);
    chk("t2_stable", stall_err, 0);
    waits = 0;
    // LEN=0 start
    cw(2'd3, 32'h2);
    cr(2'd3, v); chk("t3_cleared", v, 32'h0);
    cw(2'd2, 32'h0);
    req_cnt = 0;
    cw(2'd3, 32'h1);
    cr(2'd3, v); chk("t3_done", v, 32'h2);
    repeat (3) @(negedge clk);
    chk("t3_noreq", req_cnt, 0);
    // SRC write and start while busy are ignored
    prog(30'h300, 30'h400, 16'd2);
    cw(2'd3, 32'h3);
    repeat (2) @(negedge clk);
    cw(2'd0, 32'h555);
    cw(2'd3, 32'h1);
    wait_done(cyc);
    chk("t4_nrd", rd_log.size(), 2);
    chk("t4_rd1", rd_log[1], 32'h301);
    chk("t4_wd1", wd_log[1], 32'hDEAD0301);
    cr(2'd0, v); chk("t4_src", v, 32'h302);
    // Address wrap
    prog(30'h3FFFFFFF, 30'h10, 16'd2);
    cw(2'd3, 32'h3);
    wait_done(cyc);
    chk("t5_rd0", rd_log[0], 32'h3FFFFFFF);
    chk("t5_rd1", rd_log[1], 32'h0);
    chk("t5_wd0", wd_log[0], 32'hE152FFFF);
    cr(2'd0, v); chk("t5_src", v, 32'h1);
    cw(2'd3, 32'h4);
    cr(2'd3, v);
`ifdef DMA_IRQ_EN
    chk("irq_en_bit", v, 32'h6);
    cw(2'd3, 32'h0);
`else
    chk("irq_en_bit", v, 32'h2);
`endif
    // Asynchronous reset during the second of four words
    prog(30'h900, 30'hA00, 16'd4);
    cw(2'd3, 32'h3);
    repeat (5) @(negedge clk);
    chk("t6_pre_read", {31'd0, bus_rd}, 32'h1);
    chk("t6_pre_addr", {2'b0, bus_addr}, 32'h901);
    #2 rst = 1'b1;
    #1;
    chk("t6_strobes", {29'd0, req, bus_rd, bus_wr}, 32'h0);
    cr(2'd0, v); chk("t6_src", v, 32'h0);
    cr(2'd1, v); chk("t6_dst", v, 32'h0);
    cr(2'd2, v); chk("t6_len", v, 32'h0);
    cr(2'd3, v); chk("t6_status", v, 32'h0);
    chk("t6_nwr", wr_log.size(), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Grant gating
    gnt = 1'b0;
    ungr_err = 0;
    prog(30'h700, 30'h800, 16'd1);
    cw(2'd3, 32'h1);
    repeat (10) @(negedge clk);
    chk("t7_req", {31'd0, req}, 32'h1);
    chk("t7_nostrobe", rd_log.size(), 0);
    gnt = 1'b1;
    wait_done(cyc);
    chk("t7_ungranted", ungr_err, 0);
    chk("t7_wr0", wr_log[0], 32'h800);
    chk("t7_wd0", wd_log[0], 32'hDEAD0700);
`ifdef DMA_IRQ_EN
    cw(2'd3, 32'h6);
    chk("t8_irq_idle", {31'd0, irq}, 32'h0);
    prog(30'h20, 30'h40, 16'd1);
    cw(2'd3, 32'h5);
    wait_done(cyc);
    @(negedge clk);
    chk("t8_irq_set", {31'd0, irq}, 32'h1);
    cw(2'd3, 32'h6);
    chk("t8_irq_clr", {31'd0, irq}, 32'h0);
`endif
    chk("byteen_out", be_err, 0);
    chk("stable_all", stall_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
